// File: rtl/mdu_seq_if.sv
// Issue/result bundle between the EX-stage issue logic and the multi-cycle
// multiply/divide unit. The issuer drives start/mdop/a/b and observes the
// busy/done handshake plus the architectural HI/LO registers.
interface mdu_seq_if;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // Issue side: the pipeline that launches ops and reads HI/LO
    modport master (
        output start,
        output mdop,
        output a,
        output b,
        input  busy,
        input  done,
        input  hi,
        input  lo
    );

    // Unit side: the multiply/divide engine itself
    modport slave (
        input  start,
        input  mdop,
        input  a,
        input  b,
        output busy,
        output done,
        output hi,
        output lo
    );
endinterface

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit for the MIPS EX stage.
// The full 64-bit result is computed from the operands sampled at the accepted
// start edge and parked in pending registers; a down-counter then models the
// fixed pipeline latency before HI/LO are updated. HI/LO keep their pre-op
// values for the whole run so mfhi/mflo issued early read stale-but-stable data,
// and the stall controller keys off busy to prevent that in practice.
module mdu_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,      // asynchronous, active low
    mdu_seq_if.slave    bus
);

    // ------------------------------------------------------------------
    // Operation encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // Counter sized to hold the longer of the two latencies
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Arithmetic helper: returns {hi, lo} for an arithmetic mdop.
    // The divide corner cases are resolved here rather than left to the
    // divider so the overflow and divide-by-zero results are architectural
    // and not implementation defined.
    // ------------------------------------------------------------------
    function automatic logic [63:0] md_result(
        input logic [2:0]  op,
        input logic [31:0] x,
        input logic [31:0] y
    );
        logic signed [63:0] sprod;
        logic        [63:0] uprod;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        logic        [31:0] uq;
        logic        [31:0] ur;
        logic        [63:0] res;

        sprod = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        uprod = {32'd0, x} * {32'd0, y};
        sq    = 32'sd0;
        sr    = 32'sd0;
        uq    = 32'd0;
        ur    = 32'd0;
        res   = 64'd0;

        case (op)
            OP_MULT: begin
                res = sprod;
            end
            OP_MULTU: begin
                res = uprod;
            end
            OP_DIV: begin
                if (y == 32'd0) begin
                    // Divide by zero: all-ones quotient, dividend as remainder
                    res = {x, 32'hFFFF_FFFF};
                end else if ((x == 32'h8000_0000) && (y == 32'hFFFF_FFFF)) begin
                    // Most-negative / -1 overflows; quotient wraps, remainder 0
                    res = {32'd0, 32'h8000_0000};
                end else begin
                    // Truncating division: remainder follows the dividend sign
                    sq  = $signed(x) / $signed(y);
                    sr  = $signed(x) % $signed(y);
                    res = {sr, sq};
                end
            end
            OP_DIVU: begin
                if (y == 32'd0) begin
                    res = {x, 32'hFFFF_FFFF};
                end else begin
                    uq  = x / y;
                    ur  = x % y;
                    res = {ur, uq};
                end
            end
            default: begin
                res = 64'd0;
            end
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [63:0]        pend_q;
    logic [63:0]        pend_d;
    logic [31:0]        hi_q;
    logic [31:0]        hi_d;
    logic [31:0]        lo_q;
    logic [31:0]        lo_d;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               done_d;

    // Decode helpers
    logic               is_arith_s;
    logic               is_mult_s;
    logic               accept_s;
    logic               finish_s;
    logic               wr_hi_s;
    logic               wr_lo_s;

    // Decode the issue request; anything arriving outside IDLE is dropped
    always_comb begin
        is_arith_s = (bus.mdop == OP_MULT) || (bus.mdop == OP_MULTU) ||
                     (bus.mdop == OP_DIV)  || (bus.mdop == OP_DIVU);
        is_mult_s  = (bus.mdop == OP_MULT) || (bus.mdop == OP_MULTU);
        accept_s   = (state_q == IDLE) && bus.start && is_arith_s;
        wr_hi_s    = (state_q == IDLE) && bus.start && (bus.mdop == OP_MTHI);
        wr_lo_s    = (state_q == IDLE) && bus.start && (bus.mdop == OP_MTLO);
        finish_s   = (state_q == RUN) && (cnt_q == CNT_ONE);
    end

    // State register: FSM, latency counter, pending result, HI/LO, handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: launch on an accepted arithmetic op, count down in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = RUN;
                    cnt_d   = is_mult_s ? CNT_MULT : CNT_DIV;
                end else begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            RUN: begin
                // The edge that takes the counter from 1 to 0 retires the op
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Output logic: pending capture, HI/LO writes and the busy/done handshake
    always_comb begin
        pend_d = pend_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = (state_d == RUN);
        done_d = finish_s;

        if (accept_s) begin
            // Operands only matter at this edge; later a/b changes are ignored
            pend_d = md_result(bus.mdop, bus.a, bus.b);
        end else begin
            pend_d = pend_q;
        end

        if (finish_s) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
        end else if (wr_hi_s) begin
            hi_d = bus.a;
            lo_d = lo_q;
        end else if (wr_lo_s) begin
            hi_d = hi_q;
            lo_d = bus.a;
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // Drive the bus from registered state only
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: a table of arithmetic vectors with hand-computed
// HI/LO results, plus sequences for reset, mthi/mtlo, issue-while-busy and
// operand hold.
module tb_mdu_seq;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_NOP   = 3'd6;
    localparam int         NM       = 5;
    localparam int         ND       = 10;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } vec_t;

    logic        clk;
    logic        reset;
    mdu_seq_if   bus();

    int          n_checks;
    int          n_fail;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    vec_t        vecs[10];

    mdu_seq #(.MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one arithmetic op and follow it to completion.
    // scramble: change a/b every run cycle; inject: issue mthi/mult while busy.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int en, input bit scramble, input bit inject);
        int busy_cyc;
        int guard;
        bit hold_ok;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mdop  = op;
        bus.a     = xa;
        bus.b     = xb;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cyc  = 0;
        guard     = 0;
        hold_ok   = 1'b1;
        while (bus.done !== 1'b1 && guard < 64) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.hi !== m_hi || bus.lo !== m_lo) hold_ok = 1'b0;
            if (scramble) begin
                bus.a = $urandom;
                bus.b = $urandom;
            end
            if (inject && guard < 2) begin
                bus.start = 1'b1;
                bus.mdop  = (guard == 0) ? OP_MTHI : OP_MULT;
                bus.a     = 32'd1;
                bus.b     = 32'd9;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b0;
        check({name, " completes"}, {31'd0, bus.done}, 32'd1);
        check({name, " busy cycles"}, busy_cyc, en);
        check({name, " hi/lo hold in run"}, {31'd0, hold_ok}, 32'd1);
        check({name, " busy low at done"}, {31'd0, bus.busy}, 32'd0);
        check({name, " hi"}, bus.hi, ehi);
        check({name, " lo"}, bus.lo, elo);
        m_hi = ehi;
        m_lo = elo;
        @(negedge clk);
        check({name, " done single pulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        bit saw;
        n_checks  = 0;
        n_fail    = 0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        bus.start = 1'b0;
        bus.mdop  = OP_NOP;
        bus.a     = 32'd0;
        bus.b     = 32'd0;

        vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, NM};
        vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, NM};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, ND};
        vecs[3] = '{OP_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         ND};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, ND};
        vecs[5] = '{OP_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, ND};
        vecs[6] = '{OP_DIV,   32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF, ND};
        vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, ND};
        vecs[8] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        NM};
        vecs[9] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        NM};

        // Reset held with random activity on the inputs
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.start = 1'($urandom);
            bus.mdop  = 3'($urandom);
            bus.a     = $urandom;
            bus.b     = $urandom;
        end
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        check("reset hi", bus.hi, 32'd0);
        check("reset lo", bus.lo, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);

        // Table-driven arithmetic vectors
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo, vecs[i].n, 1'b0, 1'b0);
        end

        // No-op encodings leave everything untouched
        @(negedge clk);
        bus.start = 1'b1;
        bus.mdop  = OP_NOP;
        bus.a     = 32'h5555_5555;
        @(negedge clk);
        bus.mdop  = 3'd7;
        check("nop6 busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("nop7 busy", {31'd0, bus.busy}, 32'd0);
        check("nop hi", bus.hi, m_hi);
        check("nop lo", bus.lo, m_lo);

        // Reset in the third run cycle of a divide aborts it
        @(negedge clk);
        bus.start = 1'b1;
        bus.mdop  = OP_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort hi", bus.hi, 32'd0);
        check("abort lo", bus.lo, 32'd0);
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        saw   = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw = 1'b1;
        end
        check("abort no late done", {31'd0, saw}, 32'd0);
        check("abort hi stays", bus.hi, 32'd0);

        // mthi then mtlo on consecutive edges, never busy
        bus.start = 1'b1;
        bus.mdop  = OP_MTHI;
        bus.a     = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mthi hi", bus.hi, 32'hDEAD_BEEF);
        check("mthi lo", bus.lo, 32'd0);
        check("mthi busy", {31'd0, bus.busy}, 32'd0);
        bus.mdop  = OP_MTLO;
        bus.a     = 32'h0BAD_F00D;
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo lo", bus.lo, 32'h0BAD_F00D);
        check("mtlo hi", bus.hi, 32'hDEAD_BEEF);
        check("mtlo busy", {31'd0, bus.busy}, 32'd0);
        check("mtlo done", {31'd0, bus.done}, 32'd0);
        m_hi = 32'hDEAD_BEEF;
        m_lo = 32'h0BAD_F00D;

        // mthi and mult issued while busy are ignored
        run_op("mult busy-issue", OP_MULT, 32'd5, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'hFFFF_FFFB, NM, 1'b0, 1'b1);

        // Operand hold: a/b wander during the run
        run_op("mult operand hold", OP_MULT, 32'd6, 32'd7,
               32'd0, 32'd42, NM, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
